// File: rtl/frame_checker_if.sv
// Bus bundle for frame_checker: Avalon-MM register port plus the
// AXI-stream ingress port from the frame generator.
interface frame_checker_if;
  logic [7:0]  writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [7:0]  readdata;
  logic [15:0] ingress_port_tdata;
  logic        ingress_port_tlast;
  logic        ingress_port_tvalid;
  logic        ingress_port_tready;

  modport master (
    output writedata,
    output write,
    output chipselect,
    output address,
    output read,
    input  readdata,
    output ingress_port_tdata,
    output ingress_port_tlast,
    output ingress_port_tvalid,
    input  ingress_port_tready
  );

  modport slave (
    input  writedata,
    input  write,
    input  chipselect,
    input  address,
    input  read,
    output readdata,
    input  ingress_port_tdata,
    input  ingress_port_tlast,
    input  ingress_port_tvalid,
    output ingress_port_tready
  );
endinterface

// File: rtl/frame_checker.sv
// Frame sink/monitor: parses header, checksums payload, checks framing,
// and publishes per-frame results on an 8-bit Avalon slave.
module frame_checker #(
  parameter int MAX_PAYLOAD = 1500
) (
  input logic           clk,
  input logic           reset,
  frame_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HEADER,
    PAYLOAD,
    DRAIN,
    COMMIT
  } state_t;

  state_t state;
  state_t nxt_state;

  logic        tready_q;
  logic        acc;
  logic        tlast;
  logic [15:0] tdata;

  logic [2:0]  beat;
  logic [15:0] pay_cnt;
  logic [7:0]  sh_hdr  [16];
  logic [7:0]  vis_hdr [16];
  logic [31:0] sh_sum;
  logic [31:0] vis_sum;
  logic        sh_len;
  logic        sh_runt;
  logic        sh_over;
  logic [3:0]  vis_st;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic [7:0]  rd_mux;

  logic [15:0] len;
  logic        len_over;
  logic        last_pay;
  logic        pad;
  logic        set_len;
  logic        set_runt;
  logic        set_over;
  logic        commit;
  logic        good_f;
  logic        clr;
  logic [31:0] add_val;
  logic        unused_wdata;

  assign tdata = bus.ingress_port_tdata;
  assign tlast = bus.ingress_port_tlast;
  assign acc   = bus.ingress_port_tvalid & tready_q;

  assign bus.ingress_port_tready = tready_q;
  assign unused_wdata = ^bus.writedata;

  // Length field arrives LS byte first on the wire
  assign len      = {sh_hdr[13], sh_hdr[12]};
  assign len_over = len > 16'(MAX_PAYLOAD);
  assign last_pay = ({1'b0, pay_cnt} + 17'd2) >= {1'b0, len};
  assign pad      = last_pay & len[0];

  assign add_val = {24'd0, tdata[15:8]}
                 + (pad ? 32'd0 : {24'd0, tdata[7:0]});

  assign commit = (state == COMMIT);
  assign good_f = ~(sh_len | sh_runt | sh_over);
  assign clr    = bus.chipselect & bus.write
                & (bus.address == 8'd25);

  always_comb begin
    nxt_state = state;
    set_len   = 1'b0;
    set_runt  = 1'b0;
    set_over  = 1'b0;
    unique case (state)
      HEADER: begin
        if (acc) begin
          if (beat != 3'd7) begin
            if (tlast) begin
              nxt_state = COMMIT;
              set_runt  = 1'b1;
            end
          end else if (len_over) begin
            set_over  = 1'b1;
            set_len   = 1'b1;
            nxt_state = tlast ? COMMIT : DRAIN;
          end else if (len == 16'd0) begin
            set_len   = ~tlast;
            nxt_state = tlast ? COMMIT : DRAIN;
          end else if (tlast) begin
            set_len   = 1'b1;
            nxt_state = COMMIT;
          end else begin
            nxt_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (acc) begin
          if (last_pay) begin
            set_len   = ~tlast;
            nxt_state = tlast ? COMMIT : DRAIN;
          end else if (tlast) begin
            set_len   = 1'b1;
            nxt_state = COMMIT;
          end
        end
      end
      DRAIN: begin
        if (acc && tlast) nxt_state = COMMIT;
      end
      COMMIT: nxt_state = HEADER;
      default: nxt_state = HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HEADER;
      tready_q <= 1'b0;
    end else begin
      state    <= nxt_state;
      tready_q <= (nxt_state != COMMIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat    <= '0;
      pay_cnt <= '0;
      sh_sum  <= '0;
      vis_sum <= '0;
      sh_len  <= 1'b0;
      sh_runt <= 1'b0;
      sh_over <= 1'b0;
      vis_st  <= '0;
      for (int i = 0; i < 16; i++) begin
        sh_hdr[i]  <= '0;
        vis_hdr[i] <= '0;
      end
    end else begin
      if (acc && state == HEADER) begin
        sh_hdr[{beat, 1'b0}] <= tdata[15:8];
        sh_hdr[{beat, 1'b1}] <= tdata[7:0];
        beat <= beat + 3'd1;
      end
      if (acc && state == PAYLOAD) begin
        sh_sum  <= sh_sum + add_val;
        pay_cnt <= pay_cnt + 16'd2;
      end
      if (set_len)  sh_len  <= 1'b1;
      if (set_runt) sh_runt <= 1'b1;
      if (set_over) sh_over <= 1'b1;
      if (commit) begin
        for (int i = 0; i < 16; i++) vis_hdr[i] <= sh_hdr[i];
        vis_sum <= sh_sum;
        vis_st  <= {sh_over, sh_runt, sh_len, good_f};
        sh_sum  <= '0;
        sh_len  <= 1'b0;
        sh_runt <= 1'b0;
        sh_over <= 1'b0;
        beat    <= '0;
        pay_cnt <= '0;
      end
    end
  end

  // A clear landing on a commit leaves the committed counter at 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clr) begin
      good_cnt <= {15'd0, commit & good_f};
      bad_cnt  <= {15'd0, commit & ~good_f};
    end else if (commit) begin
      if (good_f && good_cnt != 16'hFFFF)
        good_cnt <= good_cnt + 16'd1;
      if (!good_f && bad_cnt != 16'hFFFF)
        bad_cnt <= bad_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.address < 8'd16) begin
      rd_mux = vis_hdr[bus.address[3:0]];
    end else begin
      unique case (bus.address)
        8'd16:   rd_mux = vis_sum[7:0];
        8'd17:   rd_mux = vis_sum[15:8];
        8'd18:   rd_mux = vis_sum[23:16];
        8'd19:   rd_mux = vis_sum[31:24];
        8'd20:   rd_mux = good_cnt[7:0];
        8'd21:   rd_mux = good_cnt[15:8];
        8'd22:   rd_mux = bad_cnt[7:0];
        8'd23:   rd_mux = bad_cnt[15:8];
        8'd24:   rd_mux = {4'd0, vis_st};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= (bus.chipselect & bus.read) ? rd_mux : 8'd0;
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Randomized frame stimulus for frame_checker, scored against a
// frame-level reference model of the expected register file.
module tb_frame_checker;

  localparam int MAXP = 1500;

  typedef logic [15:0] beat_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;

  frame_checker_if bus ();

  frame_checker #(.MAX_PAYLOAD(MAXP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_sh  [16];
  logic [7:0]  m_hdr [16];
  logic [31:0] m_sum;
  logic [7:0]  m_st;
  logic [15:0] m_good;
  logic [15:0] m_bad;

  bit mon_en = 1'b0;
  int low_cnt = 0;

  always @(negedge clk)
    if (mon_en && !bus.ingress_port_tready) low_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_sh[i]  = '0;
      m_hdr[i] = '0;
    end
    m_sum  = '0;
    m_st   = '0;
    m_good = '0;
    m_bad  = '0;
  endfunction

  // Outcome of one whole frame, judged from its beat list alone
  function automatic void model_frame(input beat_q_t b);
    int n;
    int len;
    int expb;
    int bi;
    logic [31:0] s;
    n = b.size();
    s = '0;
    for (int i = 0; i < n && i < 8; i++) begin
      m_sh[2*i]   = b[i][15:8];
      m_sh[2*i+1] = b[i][7:0];
    end
    for (int i = 0; i < 16; i++) m_hdr[i] = m_sh[i];
    if (n < 8) begin
      m_st = 8'h04;
    end else begin
      len  = int'({b[6][7:0], b[6][15:8]});
      expb = 8 + (len + 1) / 2;
      if (len > MAXP) m_st = 8'h0A;
      else if (len == 0) m_st = (n == 8) ? 8'h01 : 8'h02;
      else begin
        for (int k = 0; k < len; k++) begin
          bi = 8 + k / 2;
          if (bi < n)
            s += (k % 2 == 1) ? 32'(b[bi][7:0]) : 32'(b[bi][15:8]);
        end
        m_st = (n == expb) ? 8'h01 : 8'h02;
      end
    end
    m_sum = s;
    if (m_st == 8'h01) begin
      if (m_good != 16'hFFFF) m_good++;
    end else begin
      if (m_bad != 16'hFFFF) m_bad++;
    end
  endfunction

  function automatic logic [7:0] exp_reg(input int a);
    if (a < 16) return m_hdr[a];
    case (a)
      16: return m_sum[7:0];
      17: return m_sum[15:8];
      18: return m_sum[23:16];
      19: return m_sum[31:24];
      20: return m_good[7:0];
      21: return m_good[15:8];
      22: return m_bad[7:0];
      23: return m_bad[15:8];
      24: return m_st;
      default: return 8'h00;
    endcase
  endfunction

  function automatic beat_q_t mk_frame(input int len, input int n);
    beat_q_t q;
    logic [15:0] l16;
    l16 = 16'(len);
    for (int i = 0; i < n; i++)
      q.push_back(i == 6 ? {l16[7:0], l16[15:8]} : 16'($urandom));
    return q;
  endfunction

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read = 1'b1;
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    logic [7:0] d;
    for (int a = 0; a < 25; a++) begin
      rd(8'(a), d);
      check($sformatf("%s_reg%0d", pfx, a), 32'(d), 32'(exp_reg(a)));
    end
    rd(8'd25, d);
    check({pfx, "_reg25"}, 32'(d), 32'h0);
    rd(8'd200, d);
    check({pfx, "_unmapped"}, 32'(d), 32'h0);
  endtask

  task automatic send(input beat_q_t b, input bit gaps,
                      input bit clr, input bit partial);
    int i;
    int guard;
    bit v;
    bit a;
    i = 0;
    guard = 0;
    v = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      v = gaps ? ~v : 1'b1;
      bus.ingress_port_tvalid = v;
      bus.ingress_port_tdata = b[i];
      bus.ingress_port_tlast = !partial && (i == b.size() - 1);
      a = v && bus.ingress_port_tready;
      @(posedge clk);
      if (a) i++;
      guard++;
      if (guard > 4 * b.size() + 20) begin
        check("beat_timeout", 32'(i), 32'(b.size()));
        break;
      end
    end
    @(negedge clk);
    bus.ingress_port_tvalid = 1'b0;
    bus.ingress_port_tlast = 1'b0;
    if (clr) begin
      bus.chipselect = 1'b1;
      bus.write = 1'b1;
      bus.address = 8'd25;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write = 1'b0;
    end
  endtask

  task automatic run(input string tag, input beat_q_t b,
                     input bit gaps, input bit clr);
    send(b, gaps, clr, 1'b0);
    model_frame(b);
    if (clr) begin
      m_good = (m_st == 8'h01) ? 16'd1 : 16'd0;
      m_bad  = (m_st == 8'h01) ? 16'd0 : 16'd1;
    end
    repeat (2) @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_tready", 32'(bus.ingress_port_tready), 32'h0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    beat_q_t q;
    logic [7:0] d;
    int len;
    int n;
    int kind;
    int nfr;

    bus.writedata = 8'hA5;
    bus.write = 1'b0;
    bus.chipselect = 1'b0;
    bus.address = '0;
    bus.read = 1'b0;
    bus.ingress_port_tdata = '0;
    bus.ingress_port_tlast = 1'b0;
    bus.ingress_port_tvalid = 1'b0;

    do_reset();
    check_all("reset");

    q = mk_frame(4, 10);
    q[8] = 16'h0102;
    q[9] = 16'h0304;
    run("len4", q, 1'b0, 1'b0);
    rd(8'd16, d); check("len4_csum", 32'(d), 32'h0A);
    rd(8'd24, d); check("len4_status", 32'(d), 32'h01);
    rd(8'd20, d); check("len4_good", 32'(d), 32'h01);

    q = mk_frame(3, 10);
    q[8] = 16'h0A0B;
    q[9] = 16'h0CFF;
    run("len3", q, 1'b0, 1'b0);
    rd(8'd16, d); check("len3_csum", 32'(d), 32'h21);

    do_reset();
    q = mk_frame(6, 10);
    run("short", q, 1'b0, 1'b0);
    rd(8'd22, d); check("short_bad", 32'(d), 32'h01);
    rd(8'd24, d); check("short_status", 32'(d), 32'h02);
    q = mk_frame(2, 11);
    run("overrun", q, 1'b0, 1'b0);
    rd(8'd22, d); check("overrun_bad", 32'(d), 32'h02);

    do_reset();
    q = mk_frame(0, 4);
    run("runt", q, 1'b0, 1'b0);
    rd(8'd24, d); check("runt_status", 32'(d), 32'h04);
    rd(8'd22, d); check("runt_bad", 32'(d), 32'h01);
    q = mk_frame(5, 11);
    run("after_runt", q, 1'b0, 1'b0);
    rd(8'd24, d); check("after_runt_status", 32'(d), 32'h01);

    q = mk_frame(MAXP, 8 + MAXP / 2);
    run("maxlen", q, 1'b0, 1'b0);
    q = mk_frame(0, 8);
    run("len0", q, 1'b0, 1'b0);
    q = mk_frame(MAXP + 1, 12);
    run("oversize", q, 1'b0, 1'b1);
    rd(8'd24, d); check("over_status", 32'(d), 32'h0A);
    rd(8'd22, d); check("over_clr_bad", 32'(d), 32'h01);
    rd(8'd20, d); check("over_clr_good", 32'(d), 32'h00);

    low_cnt = 0;
    mon_en = 1'b1;
    nfr = 40;
    for (int f = 0; f < nfr; f++) begin
      kind = int'($urandom_range(0, 5));
      len = int'($urandom_range(1, 40));
      n = 8 + (len + 1) / 2;
      case (kind)
        1: begin
          len = int'($urandom_range(4, 40));
          n = int'($urandom_range(8, 7 + (len + 1) / 2));
        end
        2: n = n + int'($urandom_range(1, 3));
        3: n = int'($urandom_range(1, 7));
        4: begin
          len = int'($urandom_range(MAXP + 1, 65535));
          n = int'($urandom_range(8, 12));
        end
        default: ;
      endcase
      q = mk_frame(len, n);
      run($sformatf("rnd%0d", f), q, f[0], 1'b0);
    end
    mon_en = 1'b0;
    check("tready_low_cycles", 32'(low_cnt), 32'(nfr));

    q = mk_frame(40, 28);
    send(q, 1'b0, 1'b0, 1'b1);
    do_reset();
    check_all("midrst");
    q = mk_frame(7, 12);
    run("post_rst", q, 1'b1, 1'b0);
    rd(8'd20, d); check("post_rst_good", 32'(d), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
